// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared constants, pooling FSM state and signed max helper for the CNN pooling path
package cnn_pkg;

    localparam int MAP_WIDTH  = 24;
    localparam int MAP_HEIGHT = 24;
    localparam int DATA_WIDTH = 16;

    // max2 works at a fixed wide width so callers of any sample width can sign-extend into it
    localparam int MAX2_W = 32;

    typedef enum logic {
        S_EVEN = 1'b0,
        S_ODD  = 1'b1
    } pool_state_t;

    function automatic logic signed [MAX2_W-1:0] max2(
        input logic signed [MAX2_W-1:0] a,
        input logic signed [MAX2_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_combine2.sv
// rtl/pool_combine2.sv - combinational two-operand reduce: signed max, or widened sum under POOL_AVG_EN
module pool_combine2
    import cnn_pkg::*;
#(
    parameter int IN_W  = DATA_WIDTH,
    parameter int OUT_W = DATA_WIDTH
) (
    input  logic signed [IN_W-1:0]  a_i,
    input  logic signed [IN_W-1:0]  b_i,
    output logic signed [OUT_W-1:0] y_o
);

`ifdef POOL_AVG_EN
    always_comb begin
        y_o = OUT_W'(a_i) + OUT_W'(b_i);
    end
`else
    logic signed [MAX2_W-1:0] max_wide;

    always_comb begin
        max_wide = max2(MAX2_W'(a_i), MAX2_W'(b_i));
        y_o      = OUT_W'(max_wide);
    end
`endif

endmodule

// File: rtl/pool2x2_window.sv
// rtl/pool2x2_window.sv - stride-2 2x2 pooling over a two-row column stream; POOL_AVG_EN selects average pooling
module pool2x2_window
    import cnn_pkg::*;
#(
    parameter int map_width  = MAP_WIDTH,
    parameter int map_height = MAP_HEIGHT,
    parameter int data_width = DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [data_width-1:0] d_in1,
    input  logic signed [data_width-1:0] d_in2,
    input  logic                         in_valid,
    output logic signed [data_width-1:0] d_out,
    output logic                         out_valid,
    output logic                         frame_done
);

`ifdef POOL_AVG_EN
    localparam int HW = data_width + 2;
`else
    localparam int HW = data_width;
`endif
    localparam int PAIRS = map_height / 2;
    localparam int CW    = (map_width > 1) ? $clog2(map_width) : 1;
    localparam int PW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;

    pool_state_t                  state_q;
    logic signed [HW-1:0]         hold_q;
    logic [CW-1:0]                col_q, col_d;
    logic [PW-1:0]                pair_q, pair_d;
    logic signed [data_width-1:0] d_out_q;
    logic                         out_valid_q;
    logic                         frame_done_q;

    logic signed [HW-1:0]         col_red;
    logic signed [HW-1:0]         win_red;
    logic signed [data_width-1:0] win_res;
    logic                         col_last;
    logic                         pair_last;

    pool_combine2 #(.IN_W(data_width), .OUT_W(HW)) u_col_reduce (
        .a_i (d_in1),
        .b_i (d_in2),
        .y_o (col_red)
    );

    pool_combine2 #(.IN_W(HW), .OUT_W(HW)) u_win_reduce (
        .a_i (hold_q),
        .b_i (col_red),
        .y_o (win_red)
    );

    always_comb begin
        col_last  = (col_q == CW'(map_width - 1));
        pair_last = (pair_q == PW'(PAIRS - 1));
        col_d     = col_last ? '0 : col_q + 1'b1;
        pair_d    = pair_q;
        if (col_last) begin
            pair_d = pair_last ? '0 : pair_q + 1'b1;
        end
`ifdef POOL_AVG_EN
        // four-sample sum always fits in HW bits; arithmetic shift floors toward minus infinity
        win_res = data_width'(win_red >>> 2);
`else
        win_res = data_width'(win_red);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_EVEN;
            hold_q       <= '0;
            col_q        <= '0;
            pair_q       <= '0;
            d_out_q      <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            if (in_valid) begin
                col_q  <= col_d;
                pair_q <= pair_d;
                case (state_q)
                    S_EVEN: begin
                        hold_q  <= col_red;
                        state_q <= S_ODD;
                    end
                    S_ODD: begin
                        d_out_q      <= win_res;
                        out_valid_q  <= 1'b1;
                        frame_done_q <= col_last && pair_last;
                        state_q      <= S_EVEN;
                    end
                    default: state_q <= S_EVEN;
                endcase
            end
        end
    end

    assign d_out      = d_out_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pool2x2_window.sv
// tb/tb_pool2x2_window.sv - scoreboard bench for pool2x2_window on a 4x4 and a 24x24 instance; honours POOL_AVG_EN
module tb_pool2x2_window;

    localparam int DW = 16;

    typedef struct {
        int val;
        bit fd;
        int due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic                 rst_s  [2];
    logic                 iv_s   [2];
    logic signed [DW-1:0] d1_s   [2];
    logic signed [DW-1:0] d2_s   [2];
    logic signed [DW-1:0] dout_s [2];
    logic                 ov_s   [2];
    logic                 fd_s   [2];

    pool2x2_window #(.map_width(4), .map_height(4), .data_width(DW)) dut_a (
        .clk(clk), .rst(rst_s[0]), .d_in1(d1_s[0]), .d_in2(d2_s[0]), .in_valid(iv_s[0]),
        .d_out(dout_s[0]), .out_valid(ov_s[0]), .frame_done(fd_s[0])
    );

    pool2x2_window #(.map_width(24), .map_height(24), .data_width(DW)) dut_b (
        .clk(clk), .rst(rst_s[1]), .d_in1(d1_s[1]), .d_in2(d2_s[1]), .in_valid(iv_s[1]),
        .d_out(dout_s[1]), .out_valid(ov_s[1]), .frame_done(fd_s[1])
    );

    int total = 0;
    int bad = 0;

    int map_w [2] = '{4, 24};
    int map_h [2] = '{4, 24};
    int beat_n [2];
    int upper [2][24];
    int lower [2][24];
    exp_t q0[$];
    exp_t q1[$];
    int obs_a[$];
    int last_out [2];
    bit prev_ov [2];
    int ov_cnt [2];
    int fd_cnt [2];

`ifdef POOL_AVG_EN
    int ramp_exp [4] = '{3, 5, 11, 13};
    int sgn_exp  [4] = '{-5, -32768, 2, -2};
`else
    int ramp_exp [4] = '{6, 8, 14, 16};
    int sgn_exp  [4] = '{-2, -32768, 5, -1};
`endif

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int ref_pool(input int a, input int b, input int c, input int d);
        int v [4];
        int r;
        v = '{a, b, c, d};
`ifdef POOL_AVG_EN
        r = a + b + c + d;
        r = (r >= 0) ? r / 4 : -((-r + 3) / 4);
`else
        r = v[0];
        for (int i = 1; i < 4; i++) if (v[i] > r) r = v[i];
`endif
        return r;
    endfunction

    function automatic int rand16();
        logic signed [DW-1:0] r;
        r = DW'($urandom);
        return int'(r);
    endfunction

    task automatic model_beat(input int k, input int a, input int b);
        int w, pairs, col, pair;
        exp_t e;
        w     = map_w[k];
        pairs = map_h[k] / 2;
        col   = beat_n[k] % w;
        pair  = beat_n[k] / w;
        upper[k][col] = a;
        lower[k][col] = b;
        if (col % 2 == 1) begin
            e.val = ref_pool(upper[k][col-1], lower[k][col-1], a, b);
            e.fd  = (pair == pairs - 1) && (col == w - 1);
            e.due = cyc + 1;
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        beat_n[k] = (beat_n[k] + 1) % (w * pairs);
    endtask

    task automatic drive_beat(input int k, input int a, input int b);
        d1_s[k] = DW'(a);
        d2_s[k] = DW'(b);
        iv_s[k] = 1'b1;
        model_beat(k, a, b);
        @(posedge clk); #1;
        iv_s[k] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic reset_dut(input int k, input bit with_beat);
        rst_s[k] = 1'b1;
        if (with_beat) begin
            iv_s[k] = 1'b1;
            d1_s[k] = 16'sd100;
            d2_s[k] = 16'sd100;
        end
        @(posedge clk); #1;
        rst_s[k]    = 1'b0;
        iv_s[k]     = 1'b0;
        beat_n[k]   = 0;
        last_out[k] = 0;
        prev_ov[k]  = 1'b0;
        if (k == 0) q0.delete();
        else        q1.delete();
        check("reset_d_out", int'(dout_s[k]), 0);
        check("reset_out_valid", int'(ov_s[k]), 0);
        check("reset_frame_done", int'(fd_s[k]), 0);
    endtask

    task automatic feed_ramp(input int gap);
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 4; c++) begin
                drive_beat(0, (2 * p) * 4 + c + 1, (2 * p + 1) * 4 + c + 1);
                if (gap > 0) idle(gap);
            end
        end
    endtask

    task automatic check_obs(input string name, input int exp [4]);
        check({name, "_count"}, obs_a.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check(name, (obs_a.size() > i) ? obs_a[i] : -999999, exp[i]);
        end
    endtask

    task automatic feed_random_frame(input int k, input bit gaps);
        int beats;
        beats = map_w[k] * map_h[k] / 2;
        for (int i = 0; i < beats; i++) begin
            drive_beat(k, rand16(), rand16());
            if (gaps && ($urandom_range(0, 1) == 1)) idle($urandom_range(1, 3));
        end
    endtask

    task automatic monitor(input int k);
        exp_t e;
        bit got;
        if (ov_s[k]) begin
            ov_cnt[k]++;
            if (fd_s[k]) fd_cnt[k]++;
            if (prev_ov[k]) check("out_valid_back_to_back", 1, 0);
            got = 1'b0;
            if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
            if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
            if (!got) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                check("d_out", int'(dout_s[k]), e.val);
                check("frame_done", int'(fd_s[k]), int'(e.fd));
                check("latency_cycle", cyc, e.due);
            end
            if (k == 0) obs_a.push_back(int'(dout_s[k]));
            last_out[k] = int'(dout_s[k]);
        end else begin
            if (fd_s[k]) check("frame_done_without_valid", 1, 0);
            if (int'(dout_s[k]) != last_out[k]) check("d_out_hold", int'(dout_s[k]), last_out[k]);
        end
        prev_ov[k] = ov_s[k];
    endtask

    always @(negedge clk) begin
        monitor(0);
        monitor(1);
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_s[k] = 1'b1; iv_s[k] = 1'b0; d1_s[k] = '0; d2_s[k] = '0;
            beat_n[k] = 0; last_out[k] = 0; prev_ov[k] = 1'b0; ov_cnt[k] = 0; fd_cnt[k] = 0;
        end
        idle(2);
        reset_dut(0, 1'b0);
        reset_dut(1, 1'b0);

        // continuous 4x4 ramp
        obs_a.delete(); fd_cnt[0] = 0;
        feed_ramp(0);
        idle(2);
        check_obs("ramp", ramp_exp);
        check("ramp_frame_done_count", fd_cnt[0], 1);

        // signed corner windows in one 4x4 frame
        obs_a.delete();
        drive_beat(0, -5, -3);
        drive_beat(0, -7, -2);
        drive_beat(0, -32768, -32768);
        drive_beat(0, -32768, -32768);
        drive_beat(0, 1, 2);
        drive_beat(0, 3, 5);
        drive_beat(0, -1, -1);
        drive_beat(0, -1, -2);
        idle(2);
        check_obs("signed", sgn_exp);

        // same ramp with 3 idle cycles between beats
        obs_a.delete(); fd_cnt[0] = 0;
        feed_ramp(3);
        idle(2);
        check_obs("gaps", ramp_exp);
        check("gaps_frame_done_count", fd_cnt[0], 1);

        // reset after 3 beats, with a beat presented during reset
        drive_beat(0, 1, 5);
        drive_beat(0, 2, 6);
        drive_beat(0, 3, 7);
        reset_dut(0, 1'b1);
        obs_a.delete(); fd_cnt[0] = 0;
        feed_ramp(0);
        idle(2);
        check_obs("after_reset", ramp_exp);
        check("after_reset_frame_done_count", fd_cnt[0], 1);

        // random frames on the small map
        fd_cnt[0] = 0;
        for (int f = 0; f < 3; f++) feed_random_frame(0, 1'b1);
        idle(2);
        check("random_a_frame_done_count", fd_cnt[0], 3);

        // back-to-back 24x24 frames, then one with gaps
        ov_cnt[1] = 0; fd_cnt[1] = 0;
        feed_random_frame(1, 1'b0);
        feed_random_frame(1, 1'b0);
        idle(2);
        check("b2b_window_count", ov_cnt[1], 288);
        check("b2b_frame_done_count", fd_cnt[1], 2);
        feed_random_frame(1, 1'b1);
        idle(3);
        check("gap_frame_window_count", ov_cnt[1], 432);
        check("gap_frame_done_count", fd_cnt[1], 3);

        check("pending_a", q0.size(), 0);
        check("pending_b", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
